msg_burst_arbiter: RTL and testbench
====================================

Name: msg_burst_arbiter

Overview:
- Shares the single message FIFO (32-bit words, CPU-read via READ_MSG) between NUM_REQ independent report producers, e.g. the colour bounding-box writer and the edge-list writer.
- Grants whole bursts atomically in round-robin order. Each burst is prefixed with a header word. A burst is admitted only when the FIFO has room for all of it.
- Sits between the producers and the FIFO write port: it drives wrreq/data and watches usedw.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- FIFO_DEPTH, 256, message FIFO depth in words.
- USEDW_W, 8, width of the FIFO usedw input.
- MAX_BURST, 16, maximum data words per burst, excluding the header.
- LEN_W, 5, width of each burst-length field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester burst request (level)
- req_len  in  NUM_REQ*LEN_W  per-requester data-word count; requester i uses slice i
- req_data  in  NUM_REQ*32  per-requester current data word; requester i uses slice i
- ack  out  NUM_REQ  one-cycle pulse: requester's current word was consumed this cycle
- done  out  NUM_REQ  one-cycle pulse on the cycle after the requester's last word
- fifo_wrreq  out  1  FIFO write strobe
- fifo_data  out  32  FIFO write data
- fifo_usedw  in  USEDW_W  FIFO fill level
- fifo_flush  in  1  FIFO is being cleared this cycle (the same signal that drives the FIFO's clear input)
- busy  out  1  a burst is in progress (state != IDLE)
- wait_cycles  out  16  saturating count of cycles spent in IDLE with a request pending but no space

Behaviour:
- Reset: state=IDLE; rr_ptr=NUM_REQ-1; ack=0; done=0; fifo_wrreq=0; fifo_data=0; busy=0; wait_cycles=0. A reset mid-burst abandons the burst immediately: no done is issued and no further writes occur.
- Length handling: eff_len = min(req_len[i], MAX_BURST). req_len=0 gives a header-only burst.
- Space check:
  - free = FIFO_DEPTH-1-fifo_usedw - wr_last, where wr_last = 1 if fifo_wrreq was high last cycle. This compensates for the one-cycle lag of usedw.
  - A burst is admissible when free >= eff_len+1.
- IDLE:
  - Candidate = first requesting index after rr_ptr, searching upward with wrap-around.
  - If the candidate is admissible and fifo_flush=0: latch gnt=candidate and len=eff_len, set rr_ptr=candidate, go to HEADER.
  - If the candidate is not admissible, stay in IDLE. Do not skip to a shorter requester, so no reordering occurs. wait_cycles increments, saturating at 16'hFFFF.
- HEADER (1 cycle): fifo_wrreq=1; fifo_data={8'hAA, 8'(gnt), 8'h00, 8'(len)}. Go to BURST if len>0, else to DONE.
- BURST:
  - fifo_wrreq=1; fifo_data=req_data[gnt]; ack[gnt]=1; the word counter increments.
  - After len words, go to DONE.
  - The requester must present its next word on the cycle after each ack.
  - Dropping req mid-burst is ignored; the burst completes.
- DONE (1 cycle): done[gnt]=1, then return to IDLE. Consequences:
  - There is at least one idle cycle between bursts.
  - The granted requester must deassert req in the cycle it sees done, or it is treated as a new request.
- Outputs are registered. Latency:
  - req high in IDLE to header write: 1 cycle.
  - Header to first data write: 1 cycle.
  - A burst of N words occupies N+3 cycles including IDLE and DONE.
- Flush during HEADER/BURST:
  - fifo_wrreq is forced to 0 for the rest of the burst.
  - ack and done still sequence normally so the requester's protocol completes; the burst's data is dropped.
  - Flush in IDLE blocks a grant for that cycle.
- Only one requester is granted at a time. ack and done are one-hot or zero.
- Simultaneous requests: round-robin from rr_ptr. With all NUM_REQ requesting continuously, each is granted once per NUM_REQ bursts.

Test Plan:
- Single burst: reset, req[0]=1, len=3, data 0x11,0x22,0x33, usedw=0 -> writes 0xAA000003, 0x11, 0x22, 0x33 on consecutive cycles; ack[0] on the 3 data cycles; done[0] one cycle later; busy high for 5 cycles.
- Round-robin: req=2'b11 held, len=2 each, requesters deassert on done and reassert next cycle -> grant order 0,1,0,1; headers 0xAA000002 then 0xAA010002.
- Space limit: usedw=250, req[1], len=5 (needs 6, free=5) -> no write, wait_cycles counts up. Set usedw=249 -> grant next cycle, header 0xAA010005.
- Clamp and zero length: len=31 -> header len field 0x10, exactly 16 data writes. len=0 -> header 0xAA000000 only, done 1 cycle after it, no ack.
- Flush mid-burst: len=4, fifo_flush pulsed after the 2nd data word -> no further fifo_wrreq; ack still pulses 4 times total; done issued.
- Reset mid-burst: reset asserted during the 2nd data word -> next cycle all outputs 0, state IDLE, no done. After reset, requester 0 requests first (rr_ptr=NUM_REQ-1).

Source files
------------

// File: rtl/msg_burst_arbiter_if.sv
// Producer/FIFO-side bundle of the message burst arbiter.
// Latency: none, wires only.
// Backpressure: space is signalled via fifo_usedw; producers follow ack/done.
interface msg_burst_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int USEDW_W = 8,
  parameter int LEN_W   = 5
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0][31:0]      req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            done;
  logic                          fifo_wrreq;
  logic [31:0]                   fifo_data;
  logic [USEDW_W-1:0]            fifo_usedw;
  logic                          fifo_flush;
  logic                          busy;
  logic [15:0]                   wait_cycles;

  // Arbiter side: drives the FIFO write port and producer handshakes.
  modport master (
    input  req, req_len, req_data, fifo_usedw, fifo_flush,
    output ack, done, fifo_wrreq, fifo_data, busy, wait_cycles
  );

  // Environment side: producers and the FIFO.
  modport slave (
    output req, req_len, req_data, fifo_usedw, fifo_flush,
    input  ack, done, fifo_wrreq, fifo_data, busy, wait_cycles
  );
endinterface

// File: rtl/msg_burst_arbiter.sv
// Round-robin arbiter writing whole header-prefixed bursts into the message FIFO.
// Latency: request to header 1 cycle, header to first data 1 cycle, N-word burst N+3 cycles.
// Backpressure: a burst starts only when the FIFO has room for all of it; no reordering.
module msg_burst_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 8,
  parameter int MAX_BURST  = 16,
  parameter int LEN_W      = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  msg_burst_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BURST, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d, gnt_q, gnt_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic               flushed_q, flushed_d;
  logic [15:0]        wait_q, wait_d;
  logic               wr_q, wr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, done_q, done_d;
  logic [31:0]        hdr_q, hdr_d;

  logic [USEDW_W-1:0] usedw;
  logic               cand_vld, cand_ok;
  logic [IDX_W-1:0]   cand;
  logic [LEN_W-1:0]   cand_len;

  assign usedw = bus.fifo_usedw;

  // Pick the next requester after rr_q and decide whether its whole burst fits.
  always_comb begin
    int idx;
    int free;
    idx      = 0;
    free     = 0;
    cand_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!cand_vld && bus.req[idx]) begin
        cand_vld = 1'b1;
        cand     = IDX_W'(idx);
      end
    end
    cand_len = (bus.req_len[cand] > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : bus.req_len[cand];
    // usedw lags a write by one cycle, so a write last cycle still occupies a slot.
    free     = FIFO_DEPTH - 1 - int'(usedw) - int'(wr_q);
    cand_ok  = cand_vld && (free >= int'(cand_len) + 1);
  end

  // Burst sequencing and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: begin
        flushed_d = 1'b0;
        cnt_d     = '0;
        if (cand_vld) begin
          if (!cand_ok) begin
            if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
          end else if (!bus.fifo_flush) begin
            gnt_d   = cand;
            rr_d    = cand;
            len_d   = cand_len;
            state_d = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (bus.fifo_flush) flushed_d = 1'b1;
        state_d = (len_q != '0) ? S_BURST : S_DONE;
      end
      S_BURST: begin
        if (bus.fifo_flush) flushed_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == len_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flushed burst keeps its ack/done timing but stops writing.
    wr_d   = ((state_d == S_HEADER) || (state_d == S_BURST)) && !flushed_d;
    ack_d  = '0;
    done_d = '0;
    if (state_d == S_BURST) ack_d[gnt_d]  = 1'b1;
    if (state_d == S_DONE)  done_d[gnt_d] = 1'b1;
    hdr_d  = (state_d == S_HEADER) ? {8'hAA, 8'(gnt_d), 8'h00, 8'(len_d)} : 32'h0;
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      rr_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      wait_q    <= '0;
      wr_q      <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      hdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      wait_q    <= wait_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      hdr_q     <= hdr_d;
    end
  end

  // Data words pass straight from the granted producer so it can advance right after each ack.
  assign bus.fifo_data   = (state_q == S_BURST) ? bus.req_data[gnt_q] : hdr_q;
  assign bus.fifo_wrreq  = wr_q;
  assign bus.ack         = ack_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.wait_cycles = wait_q;
endmodule

// File: tb/tb_msg_burst_arbiter.sv
// Self-checking bench for msg_burst_arbiter: directed scenarios plus randomized bursts.
// Latency: checks exact cycle timing of header, data, ack and done.
// Backpressure: exercises the FIFO space check, flush and mid-burst reset.
module tb_msg_burst_arbiter;
  localparam int NUM_REQ = 2, FIFO_DEPTH = 256, USEDW_W = 8, MAX_BURST = 16, LEN_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  msg_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .USEDW_W(USEDW_W), .LEN_W(LEN_W)) bus ();

  msg_burst_arbiter #(
    .NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .USEDW_W(USEDW_W),
    .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Snapshot of DUT outputs taken at each falling edge.
  logic               s_wr;
  logic [31:0]        s_dat;
  logic [NUM_REQ-1:0] s_ack, s_done;
  logic               s_busy;
  logic [15:0]        s_wait;

  logic [31:0] wr_log[$];
  logic [31:0] hdr_log[$];
  int          ack_cnt[NUM_REQ];
  int          done_cnt[NUM_REQ];
  int          viol;
  logic        prev_busy;

  // Producer models: word buffer per requester plus an optional burst plan.
  logic [31:0] pwords[NUM_REQ][32];
  int          pidx[NUM_REQ];
  int          plan_len[NUM_REQ][8];
  logic [31:0] plan_dat[NUM_REQ][8][32];
  int          plan_n[NUM_REQ];
  int          plan_pos[NUM_REQ];
  bit          auto_rearm;
  bit          rearm[NUM_REQ];

  task automatic present(input int i, input int len);
    bus.req_len[i]  = LEN_W'(len);
    pidx[i]         = 0;
    bus.req_data[i] = pwords[i][0];
    bus.req[i]      = 1'b1;
  endtask

  task automatic load_plan(input int i);
    for (int k = 0; k < 32; k++) pwords[i][k] = plan_dat[i][plan_pos[i]][k];
    present(i, plan_len[i][plan_pos[i]]);
    plan_pos[i]++;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    hdr_log.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_cnt[i] = 0; done_cnt[i] = 0; rearm[i] = 1'b0;
    end
    viol = 0;
  endtask

  // One clock: sample outputs, then let the producers react to ack/done.
  task automatic tick();
    @(negedge clk);
    s_wr   = bus.fifo_wrreq;
    s_dat  = bus.fifo_data;
    s_ack  = bus.ack;
    s_done = bus.done;
    s_busy = bus.busy;
    s_wait = bus.wait_cycles;
    if (s_busy && !prev_busy) hdr_log.push_back(s_dat);
    prev_busy = s_busy;
    if (s_wr) wr_log.push_back(s_dat);
    if ($countones(s_ack) > 1 || $countones(s_done) > 1) viol++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rearm[i]) begin
        rearm[i] = 1'b0;
        load_plan(i);
      end
      if (s_ack[i]) begin
        ack_cnt[i]++;
        pidx[i]++;
        bus.req_data[i] = (pidx[i] < 32) ? pwords[i][pidx[i]] : 32'h0;
      end
      if (s_done[i]) begin
        done_cnt[i]++;
        bus.req[i] = 1'b0;
        if (auto_rearm && plan_pos[i] < plan_n[i]) rearm[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.req        = '0;
    bus.req_len    = '0;
    bus.req_data   = '0;
    bus.fifo_usedw = '0;
    bus.fifo_flush = 1'b0;
    auto_rearm     = 1'b0;
    repeat (3) tick();
    reset     = 1'b0;
    prev_busy = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({s_wr, s_ack, s_done, s_busy} !== '0) $display("FAIL reset_ctl: got wr=%0b ack=%b done=%b busy=%0b want all 0", s_wr, s_ack, s_done, s_busy);
    else n_pass++;
    n_checks++;
    if (s_dat !== 32'h0) $display("FAIL reset_data: got %h want 0", s_dat); else n_pass++;
    n_checks++;
    if (s_wait !== 16'h0) $display("FAIL reset_wait: got %0d want 0", s_wait); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_burst();
    logic [31:0]        e_dat[6];
    bit                 e_wr[6], e_busy[6];
    logic [NUM_REQ-1:0] e_ack[6], e_done[6];
    e_dat  = '{32'hAA000003, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
    e_wr   = '{1, 1, 1, 1, 0, 0};
    e_busy = '{1, 1, 1, 1, 1, 0};
    e_ack  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    e_done = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    do_reset();
    pwords[0][0] = 32'h11; pwords[0][1] = 32'h22; pwords[0][2] = 32'h33; pwords[0][3] = 32'h44;
    present(0, 3);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (s_wr !== e_wr[c] || s_busy !== e_busy[c] || s_ack !== e_ack[c] || s_done !== e_done[c] ||
          (e_wr[c] && s_dat !== e_dat[c]))
        $display("FAIL single_c%0d: got wr=%0b dat=%h ack=%b done=%b busy=%0b want wr=%0b dat=%h ack=%b done=%b busy=%0b",
                 c, s_wr, s_dat, s_ack, s_done, s_busy, e_wr[c], e_dat[c], e_ack[c], e_done[c], e_busy[c]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] e_hdr[4];
    e_hdr = '{32'hAA000002, 32'hAA010002, 32'hAA000002, 32'hAA010002};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      plan_n[i] = 2; plan_pos[i] = 0;
      for (int b = 0; b < 2; b++) begin
        plan_len[i][b] = 2;
        for (int k = 0; k < 32; k++) plan_dat[i][b][k] = $urandom;
      end
    end
    auto_rearm = 1'b1;
    load_plan(0);
    load_plan(1);
    for (int k = 0; k < 100 && (done_cnt[0] + done_cnt[1]) < 4; k++) tick();
    tick();
    n_checks++;
    if (hdr_log.size() != 4) $display("FAIL rr_bursts: got %0d want 4", hdr_log.size()); else n_pass++;
    for (int b = 0; b < 4 && b < hdr_log.size(); b++) begin
      n_checks++;
      if (hdr_log[b] !== e_hdr[b]) $display("FAIL rr_hdr%0d: got %h want %h", b, hdr_log[b], e_hdr[b]);
      else n_pass++;
    end
  endtask

  task automatic test_space_limit();
    do_reset();
    for (int k = 0; k < 32; k++) pwords[1][k] = $urandom;
    bus.fifo_usedw = 8'd250;
    present(1, 5);
    repeat (10) tick();
    n_checks++;
    if (wr_log.size() != 0 || s_busy !== 1'b0) $display("FAIL space_block: got writes=%0d busy=%0b want 0 0", wr_log.size(), s_busy);
    else n_pass++;
    n_checks++;
    if (s_wait !== 16'd10) $display("FAIL space_wait: got %0d want 10", s_wait); else n_pass++;
    bus.fifo_usedw = 8'd249;
    tick();
    n_checks++;
    if (s_wr !== 1'b1 || s_dat !== 32'hAA010005) $display("FAIL space_grant: got wr=%0b dat=%h want 1 aa010005", s_wr, s_dat);
    else n_pass++;
    for (int k = 0; k < 50 && done_cnt[1] < 1; k++) tick();
    n_checks++;
    if (ack_cnt[1] != 5 || done_cnt[1] != 1) $display("FAIL space_burst: got acks=%0d dones=%0d want 5 1", ack_cnt[1], done_cnt[1]);
    else n_pass++;
  endtask

  task automatic test_clamp_zero();
    do_reset();
    for (int k = 0; k < 32; k++) pwords[0][k] = $urandom;
    present(0, 31);
    tick();
    n_checks++;
    if (s_wr !== 1'b1 || s_dat !== 32'hAA000010) $display("FAIL clamp_hdr: got wr=%0b dat=%h want 1 aa000010", s_wr, s_dat);
    else n_pass++;
    for (int k = 0; k < 60 && done_cnt[0] < 1; k++) tick();
    n_checks++;
    if (wr_log.size() != 17 || ack_cnt[0] != 16) $display("FAIL clamp_len: got writes=%0d acks=%0d want 17 16", wr_log.size(), ack_cnt[0]);
    else n_pass++;
    n_checks++;
    if (wr_log.size() != 17 || wr_log[16] !== pwords[0][15]) $display("FAIL clamp_last: got %h want %h", (wr_log.size() > 16) ? wr_log[16] : 32'h0, pwords[0][15]);
    else n_pass++;
    clear_logs();
    present(0, 0);
    tick();
    tick();
    n_checks++;
    if (s_wr !== 1'b1 || s_dat !== 32'hAA000000) $display("FAIL zero_hdr: got wr=%0b dat=%h want 1 aa000000", s_wr, s_dat);
    else n_pass++;
    tick();
    n_checks++;
    if (s_done !== 2'b01 || s_ack !== 2'b00 || s_wr !== 1'b0) $display("FAIL zero_done: got done=%b ack=%b wr=%0b want 01 00 0", s_done, s_ack, s_wr);
    else n_pass++;
    tick();
    n_checks++;
    if (wr_log.size() != 1 || ack_cnt[0] != 0) $display("FAIL zero_total: got writes=%0d acks=%0d want 1 0", wr_log.size(), ack_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 32; k++) pwords[0][k] = $urandom;
    present(0, 4);
    repeat (3) tick();
    bus.fifo_flush = 1'b1;
    tick();
    bus.fifo_flush = 1'b0;
    n_checks++;
    if (s_wr !== 1'b0 || s_ack !== 2'b01) $display("FAIL flush_cut: got wr=%0b ack=%b want 0 01", s_wr, s_ack);
    else n_pass++;
    for (int k = 0; k < 20 && done_cnt[0] < 1; k++) tick();
    tick();
    n_checks++;
    if (wr_log.size() != 3 || ack_cnt[0] != 4 || done_cnt[0] != 1)
      $display("FAIL flush_total: got writes=%0d acks=%0d dones=%0d want 3 4 1", wr_log.size(), ack_cnt[0], done_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 32; k++) pwords[0][k] = $urandom;
    present(0, 4);
    repeat (3) tick();
    reset   = 1'b1;
    bus.req = '0;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({s_wr, s_ack, s_done, s_busy} !== '0 || s_dat !== 32'h0)
      $display("FAIL rstmid_out: got wr=%0b dat=%h ack=%b done=%b busy=%0b want all 0", s_wr, s_dat, s_ack, s_done, s_busy);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (done_cnt[0] != 0 || wr_log.size() != 3) $display("FAIL rstmid_quiet: got dones=%0d writes=%0d want 0 3", done_cnt[0], wr_log.size());
    else n_pass++;
    for (int k = 0; k < 32; k++) pwords[1][k] = $urandom;
    present(0, 1);
    present(1, 1);
    tick();
    n_checks++;
    if (s_wr !== 1'b1 || s_dat !== 32'hAA000001) $display("FAIL rstmid_first: got wr=%0b dat=%h want 1 aa000001", s_wr, s_dat);
    else n_pass++;
    repeat (8) tick();
  endtask

  // Random burst plans against a burst-level round-robin schedule.
  task automatic test_random();
    logic [31:0] exp_q[$];
    int          exp_ack[NUM_REQ];
    int          rem[NUM_REQ];
    int          last, total, j, b, e, got_done, bad;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      bus.fifo_usedw = USEDW_W'($urandom_range(0, 200));
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        plan_n[i] = $urandom_range(1, 4); plan_pos[i] = 0;
        rem[i] = plan_n[i]; exp_ack[i] = 0; total += plan_n[i];
        for (int p = 0; p < plan_n[i]; p++) begin
          plan_len[i][p] = $urandom_range(0, 31);
          for (int k = 0; k < 32; k++) plan_dat[i][p][k] = $urandom;
        end
      end
      exp_q.delete();
      last = NUM_REQ - 1;
      for (int n = 0; n < total; n++) begin
        j = -1;
        for (int k = 1; k <= NUM_REQ && j < 0; k++)
          if (rem[(last + k) % NUM_REQ] > 0) j = (last + k) % NUM_REQ;
        b = plan_n[j] - rem[j];
        e = (plan_len[j][b] > MAX_BURST) ? MAX_BURST : plan_len[j][b];
        exp_q.push_back({8'hAA, 8'(j), 8'h00, 8'(e)});
        for (int w = 0; w < e; w++) exp_q.push_back(plan_dat[j][b][w]);
        exp_ack[j] += e;
        rem[j]--;
        last = j;
      end
      auto_rearm = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) load_plan(i);
      got_done = 0;
      for (int k = 0; k < 3000 && got_done < total; k++) begin
        tick();
        got_done = done_cnt[0] + done_cnt[1];
      end
      tick();
      n_checks++;
      if (got_done != total) $display("FAIL rand%0d_done: got %0d want %0d", r, got_done, total); else n_pass++;
      bad = -1;
      for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
        if (bad < 0 && wr_log[k] !== exp_q[k]) bad = k;
      n_checks++;
      if (wr_log.size() != exp_q.size() || bad >= 0)
        $display("FAIL rand%0d_stream: got %0d words (first diff %0d) want %0d words", r, wr_log.size(), bad, exp_q.size());
      else n_pass++;
      n_checks++;
      if (ack_cnt[0] != exp_ack[0] || ack_cnt[1] != exp_ack[1])
        $display("FAIL rand%0d_acks: got %0d,%0d want %0d,%0d", r, ack_cnt[0], ack_cnt[1], exp_ack[0], exp_ack[1]);
      else n_pass++;
      n_checks++;
      if (viol != 0 || s_wait !== 16'h0 || s_busy !== 1'b0)
        $display("FAIL rand%0d_misc: got onehot_viol=%0d wait=%0d busy=%0b want 0 0 0", r, viol, s_wait, s_busy);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_space_limit();
    test_clamp_zero();
    test_flush();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
